// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU front end.
// The fetch stage and the decoder read instruction fields at the same positions.
package cpu_pkg;

  localparam int PC_W  = 4;
  localparam int INS_W = 16;

  localparam logic [PC_W-1:0] RESET_PC = 4'h0;

  // Opcode field INS[10:8]. The jump/branch target is INS[7:4].
  localparam int OPC_LSB = 8;
  localparam int OPC_W   = 3;
  localparam int TGT_LSB = 4;

  localparam logic [OPC_W-1:0] OPC_JMP = 3'b011;
  localparam logic [OPC_W-1:0] OPC_BRZ = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ins_fetch_pc_next.sv
// Combinational next-PC select: increment, unconditional jump, or branch-if-zero.
// The result is meaningful only in the cycle the decoder accepts the instruction.
module pc_next
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0]  i_pc,
  input  logic [OPC_W-1:0] i_opc,
  input  logic [PC_W-1:0]  i_tgt,
  input  logic             i_zero,
  output logic [PC_W-1:0]  o_next_pc
);

  logic w_is_jmp;
  logic w_is_brz;
  logic w_take;

  assign w_is_jmp = (i_opc == OPC_JMP);
  assign w_is_brz = (i_opc == OPC_BRZ);
  assign w_take   = w_is_jmp | (w_is_brz & i_zero);

  // Increment wraps naturally at 2^PC_W.
  assign o_next_pc = w_take ? i_tgt : (i_pc + 1'b1);

endmodule

// File: rtl/ins_fetch.sv
// Fetch stage: holds the PC, reads one instruction at a time from instruction
// memory and hands it to the decoder, then redirects on JMP/BRZ.
//
// Handshakes: imem_req stays high until imem_ack; imem_data is captured in
// the ack cycle. ins_valid stays high with INS stable until ins_ready; the
// transfer happens on the rising edge where both are 1.
module ins_fetch
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_data,
  output logic [INS_W-1:0] INS,
  output logic             ins_valid,
  input  logic             ins_ready,
  input  logic             zero_flag,
  output logic [PC_W-1:0]  PC,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  fetch_state_t     r_state;
  fetch_state_t     w_state_next;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_next;
  logic [INS_W-1:0] r_ins;
  logic             r_valid;
  logic             w_fill;
  logic             w_accept;

  always_comb begin
    w_state_next = r_state;
    w_fill       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (run) w_state_next = FETCH;
      end
      FETCH: begin
        // run is not consulted here; an issued request always completes.
        if (imem_ack) begin
          w_fill       = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (ins_ready) begin
          w_accept     = 1'b1;
          w_state_next = run ? FETCH : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_ins   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_fill) begin
        r_ins   <= imem_data;
        r_valid <= 1'b1;
      end
      if (w_accept) begin
        r_valid <= 1'b0;
        r_pc    <= w_pc_next;
      end
    end
  end

  pc_next u_pc_next (
    .i_pc      (r_pc),
    .i_opc     (r_ins[OPC_LSB +: OPC_W]),
    .i_tgt     (r_ins[TGT_LSB +: PC_W]),
    .i_zero    (zero_flag),
    .o_next_pc (w_pc_next)
  );

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign INS         = r_ins;
  assign ins_valid   = r_valid;
  assign PC          = r_pc;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed scenarios plus randomized
// programs checked against a rule-level PC/instruction model.
module tb_ins_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [3:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] INS;
  logic        ins_valid;
  logic        ins_ready;
  logic        zero_flag;
  logic [3:0]  PC;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // memory model: ack comes ack_delay cycles after the request rises
  logic [15:0] mem [16];
  int          ack_delay;
  logic        ack_auto;
  logic        ack_force;
  int          wait_cnt;
  logic [15:0] req_seen;
  logic        clr_seen;
  logic [3:0]  exp_q [$];

  always #5 clk = ~clk;

  assign imem_ack  = ack_force | (ack_auto & imem_req & (wait_cnt >= ack_delay));
  assign imem_data = imem_ack ? mem[imem_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
    if (clr_seen)      req_seen <= '0;
    else if (imem_req) req_seen[imem_addr] <= 1'b1;
  end

  ins_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .INS         (INS),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .zero_flag   (zero_flag),
    .PC          (PC),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    run       = 1'b0;
    ins_ready = 1'b0;
    zero_flag = 1'b0;
    ack_auto  = 1'b1;
    ack_force = 1'b0;
    ack_delay = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic clear_seen();
    clr_seen = 1'b1;
    step();
    clr_seen = 1'b0;
  endtask

  function automatic int ref_next(input int pc, input logic [15:0] w, input bit z);
    int opc;
    int tgt;
    opc = (int'(w) >> 8) & 7;
    tgt = (int'(w) >> 4) & 15;
    if (opc == 3 || (opc == 4 && z)) return tgt;
    return (pc + 1) % 16;
  endfunction

  task automatic fill_nops();
    for (int i = 0; i < 16; i++) mem[i] = 16'(16'h0800 | (i << 12) | i);
  endtask

  // Runs from reset PC until n_acc instructions are accepted, checking every cycle.
  task automatic run_prog(input int n_acc, input int max_cyc, input bit rnd_rdy,
                          input int zmode, input int dmax);
    int  m_pc;
    int  acc;
    int  cyc;
    bit  hit;
    m_pc = 0;
    acc  = 0;
    cyc  = 0;
    exp_q.delete();
    run  = 1'b1;
    while (acc < n_acc && cyc < max_cyc) begin
      if (imem_req)  check("fetch_addr", imem_addr, m_pc);
      if (ins_valid) check("ins_word", INS, mem[m_pc]);
      check("req_xor_valid", imem_req & ins_valid, 0);
      ins_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      zero_flag = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      ack_delay = $urandom_range(0, dmax);
      hit = ins_valid && ins_ready;
      if (hit) begin
        exp_q.push_back(4'(ref_next(m_pc, mem[m_pc], zero_flag)));
        acc++;
      end
      step();
      cyc++;
      if (hit) begin
        m_pc = exp_q.pop_front();
        check("pc_after_accept", PC, m_pc);
      end
    end
    check("accept_timeout", acc, n_acc);
    ins_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_seen = 1'b0;
    fill_nops();

    // reset state
    do_reset();
    check("rst_pc", PC, 0);
    check("rst_valid", ins_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_ins", INS, 0);
    check("rst_state", dbg_state, IDLE);
    step();
    check("idle_hold_busy", busy, 0);

    // sequential NOPs: one instruction per 2 cycles, PC wraps 15 -> 0
    run = 1'b1;
    ins_ready = 1'b1;
    step();
    check("nop_first_req", imem_req, 1);
    check("nop_first_addr", imem_addr, 0);
    for (int k = 0; k < 17; k++) begin
      step();
      check("nop_valid", ins_valid, 1);
      check("nop_ins", INS, mem[k % 16]);
      check("nop_pc", PC, k % 16);
      check("nop_req_low", imem_req, 0);
      step();
      check("nop_gap_valid", ins_valid, 0);
      check("nop_gap_req", imem_req, 1);
      check("nop_gap_addr", imem_addr, (k + 1) % 16);
    end

    // JMP to 5 from address 2: address 3 is never requested
    fill_nops();
    mem[2] = 16'h0350;
    do_reset();
    clear_seen();
    run_prog(5, 40, 1'b0, 0, 0);
    check("jmp_pc_end", PC, 7);
    check("jmp_skip_3", req_seen[3], 0);
    check("jmp_hit_5", req_seen[5], 1);

    // BRZ to 7 taken / not taken
    fill_nops();
    mem[1] = 16'h0470;
    do_reset();
    run_prog(2, 20, 1'b0, 1, 0);
    check("brz_taken_pc", PC, 7);
    do_reset();
    run_prog(2, 20, 1'b0, 0, 0);
    check("brz_not_taken_pc", PC, 2);

    // decoder stall for 5 cycles in ISSUE
    fill_nops();
    do_reset();
    run = 1'b1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", ins_valid, 1);
      check("stall_ins", INS, mem[0]);
      check("stall_pc", PC, 0);
      check("stall_req", imem_req, 0);
      step();
    end
    ins_ready = 1'b1;
    step();
    check("stall_release_valid", ins_valid, 0);
    check("stall_release_pc", PC, 1);
    check("stall_release_req", imem_req, 1);

    // delayed ack, run dropped while waiting
    do_reset();
    ack_delay = 3;
    run = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, 0);
      check("wait_valid", ins_valid, 0);
      if (i == 1) run = 1'b0;
      step();
    end
    check("ack_cycle_valid", ins_valid, 0);
    step();
    check("after_ack_valid", ins_valid, 1);
    check("after_ack_ins", INS, mem[0]);
    check("after_ack_busy", busy, 1);
    ins_ready = 1'b1;
    step();
    check("stop_state", dbg_state, IDLE);
    check("stop_busy", busy, 0);
    check("stop_req", imem_req, 0);
    check("stop_pc", PC, 1);
    step();
    check("stop_hold_busy", busy, 0);

    // reset during FETCH, then a late ack is ignored
    do_reset();
    ack_delay = 100;
    run = 1'b1;
    step();
    step();
    check("rf_req_before", imem_req, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run = 1'b0;
    check("rf_pc", PC, 0);
    check("rf_valid", ins_valid, 0);
    check("rf_req", imem_req, 0);
    check("rf_ins", INS, 0);
    ack_force = 1'b1;
    step();
    step();
    ack_force = 1'b0;
    check("late_ack_valid", ins_valid, 0);
    check("late_ack_ins", INS, 0);
    check("late_ack_busy", busy, 0);

    // reset during ISSUE with PC already advanced
    do_reset();
    run = 1'b1;
    ins_ready = 1'b1;
    step();
    step();
    step();
    ins_ready = 1'b0;
    step();
    check("ri_valid_before", ins_valid, 1);
    check("ri_pc_before", PC, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run = 1'b0;
    check("ri_pc", PC, 0);
    check("ri_valid", ins_valid, 0);
    check("ri_req", imem_req, 0);
    check("ri_ins", INS, 0);

    // randomized programs, stalls, branches and ack delays
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) begin
        logic [2:0] opc;
        case ($urandom_range(0, 3))
          0:       opc = 3'b000;
          1:       opc = OPC_JMP;
          2:       opc = OPC_BRZ;
          default: opc = 3'($urandom_range(0, 7));
        endcase
        mem[i] = {5'($urandom_range(0, 31)), opc, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15))};
      end
      do_reset();
      run_prog(30, 400, 1'b1, 2, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
